// File: rtl/tree_node_pkg.sv
// rtl/tree_node_pkg.sv - shared types and default parameters for the dispatch-tree nodes
package tree_node_pkg;

    localparam int DEF_FANOUT  = 10;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 1024;
    localparam int MAX_FANOUT  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        WAIT     = 2'd2,
        REPORT   = 2'd3
    } node_state_e;

    // Reply as seen by a parent; the map is sized for the widest supported node.
    typedef struct packed {
        logic [MAX_FANOUT-1:0] done_map;
        logic                  err;
    } node_reply_t;

endpackage

// File: rtl/tree_leaf_stub.sv
// rtl/tree_leaf_stub.sv - leaf child: answers a start pulse with a done pulse work_i cycles later
module tree_leaf_stub
    import tree_node_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] work_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    // The count is preloaded one short because the done register adds the final cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (start_i) begin
                if (work_i <= CNT_W'(1)) begin
                    cnt_q  <= '0;
                    done_o <= 1'b1;
                end else begin
                    cnt_q <= work_i - CNT_W'(1);
                end
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    done_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tree_dispatch_node.sv
// rtl/tree_dispatch_node.sv - hierarchy node: fans work out to FANOUT children, merges their dones
// Optional completion timeout enabled by defining TREE_DISPATCH_NODE_TIMEOUT_EN.
module tree_dispatch_node
    import tree_node_pkg::*;
#(
    parameter int FANOUT  = DEF_FANOUT,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int STAGGER = 0,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  work_i,
    input  logic [FANOUT-1:0] mask_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [FANOUT-1:0] done_map_o,
    output logic [FANOUT-1:0] child_start_o,
    output logic [CNT_W-1:0]  child_work_o,
    input  logic [FANOUT-1:0] child_done_i
);

    localparam int PTR_W = (FANOUT > 1) ? $clog2(FANOUT) : 1;

    if (FANOUT < 1 || FANOUT > MAX_FANOUT || TIMEOUT < 1) begin : g_param_check
        $error("tree_dispatch_node: FANOUT must be 1..32 and TIMEOUT at least 1");
    end

    node_state_e       state_q, state_d;
    logic [FANOUT-1:0] mask_q;
    logic [FANOUT-1:0] done_map_q, done_map_d;
    logic [FANOUT-1:0] done_hit;
    logic [FANOUT-1:0] child_start_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              complete;

`ifdef TREE_DISPATCH_NODE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_inc;
    logic             tmo_expire;
    logic             err_d;

    assign tmo_inc    = (tmo_q == TMO_W'(TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);
    assign tmo_expire = (tmo_inc == TMO_W'(TIMEOUT));

    // Held at zero while idle, so it starts from zero on the first busy cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_o <= 1'b0;
        end else begin
            tmo_q <= (state_q == IDLE) ? '0 : tmo_inc;
            err_o <= (state_d == REPORT) && err_d;
        end
    end
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        done_map_d    = done_map_q;
        ptr_d         = ptr_q;
        child_start_d = '0;
`ifdef TREE_DISPATCH_NODE_TIMEOUT_EN
        err_d         = 1'b0;
`endif
        done_hit      = child_done_i & mask_q;
        complete      = ((done_map_q | done_hit) == mask_q);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    done_map_d = '0;
                    ptr_d      = '0;
                    if (mask_i == '0) begin
                        state_d = REPORT;
                    end else begin
                        state_d = DISPATCH;
                        if (STAGGER == 0) begin
                            child_start_d = mask_i;
                        end else begin
                            child_start_d[0] = mask_i[0];
                        end
                    end
                end
            end
            DISPATCH, WAIT: begin
                // Completion is priority over timeout and may cut a staggered dispatch short.
                done_map_d = done_map_q | done_hit;
                if (complete) begin
                    state_d = REPORT;
                end
`ifdef TREE_DISPATCH_NODE_TIMEOUT_EN
                else if (tmo_expire) begin
                    state_d = REPORT;
                    err_d   = 1'b1;
                end
`endif
                else if (state_q == DISPATCH) begin
                    if (STAGGER == 0 || ptr_q == PTR_W'(FANOUT - 1)) begin
                        state_d = WAIT;
                    end else begin
                        ptr_d                = ptr_q + PTR_W'(1);
                        child_start_d[ptr_d] = mask_q[ptr_d];
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            done_map_q    <= '0;
            ptr_q         <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            done_map_o    <= '0;
            child_start_o <= '0;
            child_work_o  <= '0;
        end else begin
            state_q       <= state_d;
            done_map_q    <= done_map_d;
            ptr_q         <= ptr_d;
            busy_o        <= (state_d != IDLE);
            done_o        <= (state_d == REPORT);
            done_map_o    <= (state_d == REPORT) ? done_map_d : '0;
            child_start_o <= child_start_d;
            if (state_q == IDLE && start_i) begin
                mask_q       <= mask_i;
                child_work_o <= work_i;
            end
        end
    end

endmodule

// File: tb/tb_tree_dispatch_node.sv
// tb/tb_tree_dispatch_node.sv - directed scoreboard bench for tree_dispatch_node and tree_leaf_stub
module tb_tree_dispatch_node;
    import tree_node_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] work_a = '0, work_b = '0;
    logic [9:0] mask_a = '0, mask_b = '0;
    logic [9:0] tb_done_a = '0, tb_done_b = '0;
    logic       use_stub = 1'b0;

    logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [9:0] map_a, cs_a, cd_a, map_b, cs_b, stub_done;
    logic [7:0] cw_a, cw_b;
    logic [30:0] outs_a, outs_b;

    node_reply_t q_a[$];
    node_reply_t q_b[$];
    node_reply_t ea, eb;

    always #5 clk = ~clk;

    assign cd_a   = use_stub ? stub_done : tb_done_a;
    assign outs_a = {busy_a, done_a, err_a, map_a, cs_a, cw_a};
    assign outs_b = {busy_b, done_b, err_b, map_b, cs_b, cw_b};

    tree_dispatch_node #(.FANOUT(10), .CNT_W(8), .STAGGER(0), .TIMEOUT(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .work_i(work_a), .mask_i(mask_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .done_map_o(map_a),
        .child_start_o(cs_a), .child_work_o(cw_a), .child_done_i(cd_a)
    );

    tree_dispatch_node #(.FANOUT(10), .CNT_W(8), .STAGGER(1), .TIMEOUT(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .work_i(work_b), .mask_i(mask_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .done_map_o(map_b),
        .child_start_o(cs_b), .child_work_o(cw_b), .child_done_i(tb_done_b)
    );

    for (genvar g = 0; g < 10; g++) begin : g_stub
        tree_leaf_stub #(.CNT_W(8)) u_stub (
            .clk(clk), .rst_n(rst_n), .start_i(cs_a[g]), .work_i(cw_a), .done_o(stub_done[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic node_reply_t reply(input logic [9:0] map, input logic err);
        node_reply_t r;
        r          = '0;
        r.done_map = 32'(map);
        r.err      = err;
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            check("done_a_expected", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) begin
                ea = q_a.pop_front();
                check("map_a", 32'(map_a), ea.done_map);
                check("err_a", 32'(err_a), 32'(ea.err));
            end
        end
        if (done_b === 1'b1) begin
            check("done_b_expected", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) begin
                eb = q_b.pop_front();
                check("map_b", 32'(map_b), eb.done_map);
                check("err_b", 32'(err_b), 32'(eb.err));
            end
        end
    end

    task automatic go_a(input logic [9:0] m, input logic [7:0] w);
        start_a = 1'b1;
        mask_a  = m;
        work_a  = w;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int cur, input int limit, output int at);
        at = cur;
        while (done_a !== 1'b1 && at < limit) begin
            tick();
            at++;
        end
    endtask

    initial begin
        int         at;
        bit         ok;
        logic [9:0] m;
        logic [9:0] exp_cs;

        repeat (3) tick();
        check("reset_outs_a", 32'(outs_a), 32'd0);
        check("reset_outs_b", 32'(outs_b), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: all ten leaf stubs, work 3
        use_stub = 1'b1;
        q_a.push_back(reply(10'h3FF, 1'b0));
        go_a(10'h3FF, 8'd3);
        check("t1_start_c1", 32'(cs_a), 32'h3FF);
        check("t1_busy_c1", 32'(busy_a), 32'd1);
        check("t1_work_c1", 32'(cw_a), 32'd3);
        tick();
        check("t1_start_c2", 32'(cs_a), 32'd0);
        tick();
        tick();
        check("t1_stub_done_c4", 32'(stub_done), 32'h3FF);
        check("t1_done_c4", 32'(done_a), 32'd0);
        tick();
        check("t1_done_c5", 32'(done_a), 32'd1);
        tick();
        check("t1_idle_c6", 32'({busy_a, done_a}), 32'd0);

        // 2: spurious and repeated child dones
        use_stub = 1'b0;
        q_a.push_back(reply(10'h005, 1'b0));
        go_a(10'h005, 8'd7);
        check("t2_start_c1", 32'(cs_a), 32'h005);
        tick();
        tb_done_a = 10'h003;
        tick();
        check("t2_done_c3", 32'(done_a), 32'd0);
        tb_done_a = 10'h001;
        tick();
        check("t2_done_c4", 32'(done_a), 32'd0);
        tb_done_a = 10'h000;
        tick();
        check("t2_done_c5", 32'(done_a), 32'd0);
        tb_done_a = 10'h004;
        tick();
        tb_done_a = 10'h000;
        check("t2_done_c6", 32'(done_a), 32'd1);
        tick();
        check("t2_busy_c7", 32'(busy_a), 32'd0);

        // 3: zero mask, with a second start held into the busy cycle
        q_a.push_back(reply(10'h000, 1'b0));
        go_a(10'h000, 8'd1);
        start_a = 1'b1;
        check("t3_done_c1", 32'({done_a, busy_a}), 32'h3);
        check("t3_start_c1", 32'(cs_a), 32'd0);
        tick();
        start_a = 1'b0;
        check("t3_idle_c2", 32'({busy_a, done_a}), 32'd0);
        tick();
        check("t3_ignored_c3", 32'(busy_a), 32'd0);

        // 4: child 3 never answers
`ifdef TREE_DISPATCH_NODE_TIMEOUT_EN
        q_a.push_back(reply(10'h3F7, 1'b1));
`else
        q_a.push_back(reply(10'h3FF, 1'b0));
`endif
        go_a(10'h3FF, 8'd2);
        tick();
        tb_done_a = 10'h3F7;
        tick();
        tb_done_a = 10'h000;
`ifdef TREE_DISPATCH_NODE_TIMEOUT_EN
        wait_done_a(3, 40, at);
        check("t4_timeout_cycle", 32'(at), 32'd17);
        tick();
`else
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (busy_a !== 1'b1 || done_a !== 1'b0) ok = 1'b0;
            tick();
        end
        check("t4_hold_busy_1000", 32'(ok), 32'd1);
        tb_done_a = 10'h008;
        tick();
        tb_done_a = 10'h000;
        wait_done_a(0, 2, at);
        check("t4_late_done", 32'(at), 32'd0);
        tick();
`endif
        tick();
        check("t4_idle", 32'(busy_a), 32'd0);

        // 5: staggered dispatch, child 1 answers during DISPATCH
        q_b.push_back(reply(10'h2AA, 1'b0));
        m       = 10'h2AA;
        start_b = 1'b1;
        mask_b  = m;
        work_b  = 8'd4;
        tick();
        start_b = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_cs = m[i] ? (10'd1 << i) : 10'd0;
            if (cs_b !== exp_cs || busy_b !== 1'b1) ok = 1'b0;
            tb_done_b = (i == 2) ? 10'h002 : 10'h000;
            tick();
        end
        check("t5_stagger_c1_c10", 32'(ok), 32'd1);
        check("t5_wait_c11", 32'({busy_b, cs_b}), 32'h400);
        check("t5_nodone_c11", 32'(done_b), 32'd0);
        tb_done_b = 10'h2A8;
        tick();
        tb_done_b = 10'h000;
        check("t5_done_c12", 32'(done_b), 32'd1);
        tick();
        check("t5_idle_c13", 32'(busy_b), 32'd0);

        // 6: asynchronous reset while waiting, then a clean single-child run
        use_stub = 1'b1;
        go_a(10'h3FF, 8'd5);
        tick();
        check("t6_busy_pre_rst", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", 32'(outs_a), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("t6_quiet_after_rst", 32'({busy_a, stub_done}), 32'd0);
        q_a.push_back(reply(10'h001, 1'b0));
        go_a(10'h001, 8'd2);
        check("t6_start_c1", 32'(cs_a), 32'h001);
        wait_done_a(1, 20, at);
        check("t6_done_cycle", 32'(at), 32'd4);
        tick();
        tick();

        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tree_dispatch_node.md
# tree_dispatch_node

Parametrised hierarchy node that fans a work request out to `FANOUT` children and collects their completions into one reply to its parent. It is the next-generation replacement for the fixed ten-child, port-less hierarchy nodes in the synthetic module trees. Nodes stack to arbitrary depth: a node's `child_*` ports connect to child nodes or to `tree_leaf_stub` instances. It adds a start/done handshake, a child enable mask, staggered dispatch and an optional timeout.

## Interface
- `FANOUT`, 10, number of child channels (1..32)
- `CNT_W`, 8, width of the work token
- `STAGGER`, 0, 0 = start all children together; 1 = start one child index per cycle
- `TIMEOUT`, 1024, cycles allowed from leaving IDLE to completion (only used with the timeout macro)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  request pulse; accepted only when `busy_o`=0
- `work_i`  in  CNT_W  work token, sampled with `start_i`
- `mask_i`  in  FANOUT  child enables, sampled with `start_i`
- `busy_o`  out  1  high in every state except IDLE
- `done_o`  out  1  one-cycle completion pulse
- `err_o`  out  1  timeout flag, valid only while `done_o`=1
- `done_map_o`  out  FANOUT  children that completed, valid only while `done_o`=1
- `child_start_o`  out  FANOUT  per-child one-cycle start pulse
- `child_work_o`  out  CNT_W  latched token, held stable while busy
- `child_done_i`  in  FANOUT  per-child one-cycle done pulse

## Operation
- FSM states: IDLE, DISPATCH, WAIT, REPORT.
- **IDLE:** when `start_i`=1, latch `work_i` and `mask_i` and clear `done_map`.
  - If the latched mask is 0, go to REPORT.
  - Otherwise go to DISPATCH.
- **`start_i` while busy:** ignored; requests are not queued.
- **DISPATCH, STAGGER=0:** drive `child_start_o`=mask for one cycle, then go to WAIT.
- **DISPATCH, STAGGER=1:** pointer p runs 0..FANOUT-1 at one index per cycle, including disabled indices.
  - `child_start_o[p]`=mask[p].
  - Go to WAIT after p=FANOUT-1.
- **Done collection (DISPATCH and WAIT):** `done_map |= child_done_i & mask`.
  - Done pulses from masked-off children are ignored.
  - Repeated pulses from the same child are ignored.
- **Completion:** when `(done_map | (child_done_i & mask)) == mask`, go to REPORT. This check is also evaluated during DISPATCH.
- **REPORT:** `done_o`=1 for one cycle, `done_map_o`=done_map, then go to IDLE.
- **Timeout counter:** `$clog2(TIMEOUT+1)` bits wide, saturating; cleared on leaving IDLE.
- **Reset:** all outputs 0, FSM in IDLE, all registers cleared. Reset during an operation aborts it and produces no `done_o`.

## Timing
- All outputs are registered.
- `start_i` sampled at edge 0 gives `busy_o`=1 and the first `child_start_o` in cycle 1.
- Zero mask: `done_o` in cycle 1.
- The last required `child_done_i` sampled at edge k gives `done_o` in cycle k+1. `busy_o` falls in cycle k+2.
- A child may pulse done at the earliest one cycle after its start pulse.
- A new `start_i` is accepted in the first cycle with `busy_o`=0. Back-to-back throughput is one request per (dispatch + wait + 2) cycles.

## Configuration
- Macro: `TREE_DISPATCH_NODE_TIMEOUT_EN`.
- **Defined:**
  - If the counter reaches TIMEOUT in DISPATCH or WAIT before completion, go to REPORT with `err_o`=1 and `done_map_o` = the partial map.
  - If completion and timeout occur in the same cycle, completion wins and `err_o`=0.
- **Undefined:**
  - The counter is not built and `err_o` is tied to 0.
  - A missing child done holds the node in WAIT indefinitely.

## Structure
- `tree_node_pkg`:
  - `node_state_e` enum (IDLE, DISPATCH, WAIT, REPORT)
  - default parameter constants: FANOUT, CNT_W, TIMEOUT
  - `node_reply_t` struct: `done_map`, `err`
- Sub-module `tree_leaf_stub`, with ports `clk`, `rst_n`, `start_i`, `work_i`, `done_o`:
  - on start it loads `work_i` into a down-counter and pulses `done_o` `work_i` cycles later
  - `work_i`=0 is treated as 1
  - used by the bench and as the leaf of generated trees

## Test plan
1. FANOUT=10, STAGGER=0, mask=0x3FF, work=3, leaf stubs → `child_start_o`=0x3FF in cycle 1, all leaf dones in cycle 4, `done_o` in cycle 5 with map 0x3FF and `err_o`=0.
2. mask=0x005, child 1 pulses done spuriously and child 0 pulses done twice → `done_o` only after child 2's done; `done_map_o`=0x005.
3. mask=0 → `done_o`=1 in cycle 1 with map 0; `busy_o` low again in cycle 2; a second `start_i` in cycle 1 is ignored.
4. Macro defined, TIMEOUT=16, mask=0x3FF, child 3 never completes → `done_o` with `err_o`=1 and map 0x3F7, 16 cycles after leaving IDLE. Macro undefined → `busy_o` stays 1 for 1000 cycles.
5. STAGGER=1, mask=0x2AA → child i's start pulse occurs in cycle 1+i for odd i only; WAIT entered in cycle 11.
6. `rst_n` asserted in WAIT → all outputs 0 asynchronously and no `done_o`; after release, a new start with mask=0x001 completes normally.
